// File: rtl/mem_dump_checker.sv
// Runs a CPU under test for a bounded number of cycles (or until it halts), then dumps its
// data memory word by word and compares it against expected contents.
module mem_dump_checker #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned NWORDS      = 32,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned HALT_EN     = 1,
  parameter int unsigned HALT_WINDOW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       idata,
  output logic              cpu_reset,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       fail_count,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic [DATA_W-1:0] first_fail_got,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic [31:0]       cycles_run
);

  typedef enum logic [1:0] {StIdle, StRun, StDump, StDone} state_e;

  localparam logic [ADDR_W:0] LastPos = (ADDR_W + 1)'(NWORDS);
  localparam logic [31:0]     MaxCyc  = 32'(MAX_CYCLES);
  localparam logic [31:0]     HaltWin = 32'(HALT_WINDOW);
  localparam bit              HaltEn  = (HALT_EN != 0);

  state_e              state_q, state_d;
  logic [31:0]         cyc_q, cyc_d;
  logic [31:0]         zrun_q, zrun_d;
  logic [ADDR_W:0]     pos_q, pos_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0]   cmp_idx_q, cmp_idx_d;
  logic [15:0]         fail_q, fail_d;
  logic [ADDR_W-1:0]   ff_idx_q, ff_idx_d;
  logic [DATA_W-1:0]   ff_got_q, ff_got_d;
  logic [DATA_W-1:0]   ff_exp_q, ff_exp_d;
  logic                mismatch;
  logic                halt_hit;

  assign rd_en    = (state_q == StDump) && (pos_q < LastPos);
  assign rd_addr  = rd_en ? pos_q[ADDR_W-1:0] : '0;
  // rd_data/exp_data belong to the index issued on the previous cycle.
  assign mismatch = cmp_vld_q && (rd_data != exp_data);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    zrun_d    = zrun_q;
    pos_d     = pos_q;
    fail_d    = fail_q;
    ff_idx_d  = ff_idx_q;
    ff_got_d  = ff_got_q;
    ff_exp_d  = ff_exp_q;
    cmp_vld_d = rd_en;
    cmp_idx_d = rd_addr;
    halt_hit  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          cyc_d    = '0;
          zrun_d   = '0;
          pos_d    = '0;
          fail_d   = '0;
          ff_idx_d = '0;
          ff_got_d = '0;
          ff_exp_d = '0;
        end
      end
      StRun: begin
        cyc_d    = cyc_q + 32'd1;
        zrun_d   = (idata == 32'd0) ? zrun_q + 32'd1 : 32'd0;
        halt_hit = HaltEn && (zrun_d >= HaltWin);
        if ((cyc_d == MaxCyc) || halt_hit) begin
          state_d = StDump;
          pos_d   = '0;
        end
      end
      StDump: begin
        if (mismatch) begin
          if (fail_q == 16'd0) begin
            ff_idx_d = cmp_idx_q;
            ff_got_d = rd_data;
            ff_exp_d = exp_data;
          end
          if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
        end
        if (pos_q == LastPos) state_d = StDone;
        else                  pos_d   = pos_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cyc_q     <= '0;
      zrun_q    <= '0;
      pos_q     <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      fail_q    <= '0;
      ff_idx_q  <= '0;
      ff_got_q  <= '0;
      ff_exp_q  <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      zrun_q    <= zrun_d;
      pos_q     <= pos_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      fail_q    <= fail_d;
      ff_idx_q  <= ff_idx_d;
      ff_got_q  <= ff_got_d;
      ff_exp_q  <= ff_exp_d;
    end
  end

  assign cpu_reset      = (state_q != StRun);
  assign busy           = (state_q == StRun) || (state_q == StDump);
  assign done           = (state_q == StDone);
  assign pass           = done && (fail_q == 16'd0);
  assign fail_count     = fail_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_got = ff_got_q;
  assign first_fail_exp = ff_exp_q;
  assign cycles_run     = cyc_q;

endmodule

// File: tb/tb_mem_dump_checker.sv
// Bench for mem_dump_checker: three configurations share stimulus and are checked every cycle
// against a behavioural model, plus directed literal checks.
module tb_mem_dump_checker;

  localparam int PhIdle = 0, PhRun = 1, PhDump = 2, PhDone = 3;

  typedef struct {
    int          ph;
    int          cyc;
    int          zr;
    int          pos;
    int          fails;
    int          ffi;
    logic [31:0] ffg;
    logic [31:0] ffe;
  } mdl_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] idata = 32'd1;
  logic        cmp_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [31:0] got_mem [32];
  logic [31:0] exp_mem [32];

  always #5 clk = ~clk;

  // a: halt detection on, b: halt detection off, c: one word / one cycle
  logic a_cpu_reset, a_rd_en, a_busy, a_done, a_pass;
  logic [4:0] a_rd_addr, a_ffi;
  logic [15:0] a_fc;
  logic [31:0] a_rd_data, a_exp_data, a_ffg, a_ffe, a_cyc;
  logic b_cpu_reset, b_rd_en, b_busy, b_done, b_pass;
  logic [4:0] b_rd_addr, b_ffi;
  logic [15:0] b_fc;
  logic [31:0] b_rd_data, b_exp_data, b_ffg, b_ffe, b_cyc;
  logic c_cpu_reset, c_rd_en, c_busy, c_done, c_pass;
  logic [4:0] c_rd_addr, c_ffi;
  logic [15:0] c_fc;
  logic [31:0] c_rd_data, c_exp_data, c_ffg, c_ffe, c_cyc;

  mem_dump_checker #(.HALT_EN(1)) u_a (
    .clk(clk), .reset(reset), .start(start), .idata(idata), .cpu_reset(a_cpu_reset),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .exp_data(a_exp_data),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail_count(a_fc), .first_fail_idx(a_ffi),
    .first_fail_got(a_ffg), .first_fail_exp(a_ffe), .cycles_run(a_cyc)
  );
  mem_dump_checker #(.HALT_EN(0)) u_b (
    .clk(clk), .reset(reset), .start(start), .idata(idata), .cpu_reset(b_cpu_reset),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .exp_data(b_exp_data),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail_count(b_fc), .first_fail_idx(b_ffi),
    .first_fail_got(b_ffg), .first_fail_exp(b_ffe), .cycles_run(b_cyc)
  );
  mem_dump_checker #(.NWORDS(1), .MAX_CYCLES(1)) u_c (
    .clk(clk), .reset(reset), .start(start), .idata(idata), .cpu_reset(c_cpu_reset),
    .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .exp_data(c_exp_data),
    .busy(c_busy), .done(c_done), .pass(c_pass), .fail_count(c_fc), .first_fail_idx(c_ffi),
    .first_fail_got(c_ffg), .first_fail_exp(c_ffe), .cycles_run(c_cyc)
  );

  // Memory model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (a_rd_en) begin a_rd_data <= got_mem[a_rd_addr]; a_exp_data <= exp_mem[a_rd_addr]; end
    if (b_rd_en) begin b_rd_data <= got_mem[b_rd_addr]; b_exp_data <= exp_mem[b_rd_addr]; end
    if (c_rd_en) begin c_rd_data <= got_mem[c_rd_addr]; c_exp_data <= exp_mem[c_rd_addr]; end
  end

  // Behavioural model: phase, cycles run, current zero streak and dump position.
  function automatic mdl_t step(int nw, int mc, int he, int win, mdl_t m, logic rst, logic st,
                                logic [31:0] id);
    mdl_t n = m;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    case (m.ph)
      PhIdle, PhDone: if (st) begin n = '{default: 0}; n.ph = PhRun; end
      PhRun: begin
        n.cyc = m.cyc + 1;
        n.zr  = (id == 0) ? m.zr + 1 : 0;
        if (n.cyc == mc || (he != 0 && n.zr >= win)) begin n.ph = PhDump; n.pos = 0; end
      end
      PhDump: begin
        if (m.pos >= 1 && got_mem[m.pos-1] != exp_mem[m.pos-1]) begin
          if (m.fails == 0) begin
            n.ffi = m.pos - 1; n.ffg = got_mem[m.pos-1]; n.ffe = exp_mem[m.pos-1];
          end
          if (m.fails < 65535) n.fails = m.fails + 1;
        end
        if (m.pos == nw) n.ph = PhDone;
        else n.pos = m.pos + 1;
      end
      default: n.ph = PhIdle;
    endcase
    return n;
  endfunction

  function automatic logic [126:0] pack(logic cr, logic re, logic [4:0] ra, logic b, logic d,
                                        logic p, logic [15:0] fc, logic [4:0] fi,
                                        logic [31:0] fg, logic [31:0] fe, logic [31:0] cy);
    return {cr, re, ra, b, d, p, fc, fi, fg, fe, cy};
  endfunction

  function automatic logic [126:0] expv(int nw, mdl_t m);
    logic re;
    re = (m.ph == PhDump) && (m.pos < nw);
    return pack(m.ph != PhRun, re, re ? 5'(m.pos) : 5'd0, m.ph == PhRun || m.ph == PhDump,
                m.ph == PhDone, m.ph == PhDone && m.fails == 0, 16'(m.fails), 5'(m.ffi),
                m.ffg, m.ffe, 32'(m.cyc));
  endfunction

  task automatic check(input string name, input logic [126:0] got, input logic [126:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  mdl_t ma = '{default: 0}, mb = '{default: 0}, mc = '{default: 0};

  always @(posedge clk) begin
    ma = step(32, 1000, 1, 8, ma, reset, start, idata);
    mb = step(32, 1000, 0, 8, mb, reset, start, idata);
    mc = step(1, 1, 1, 8, mc, reset, start, idata);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_a", pack(a_cpu_reset, a_rd_en, a_rd_addr, a_busy, a_done, a_pass, a_fc,
                             a_ffi, a_ffg, a_ffe, a_cyc), expv(32, ma));
      check("cycle_b", pack(b_cpu_reset, b_rd_en, b_rd_addr, b_busy, b_done, b_pass, b_fc,
                             b_ffi, b_ffg, b_ffe, b_cyc), expv(32, mb));
      check("cycle_c", pack(c_cpu_reset, c_rd_en, c_rd_addr, c_busy, c_done, c_pass, c_fc,
                             c_ffi, c_ffg, c_ffe, c_cyc), expv(1, mc));
    end
  end

  int a_reads = 0, b_reads = 0, c_reads = 0, b_run_cycles = 0;
  always @(negedge clk) begin
    if (a_rd_en === 1'b1) a_reads++;
    if (b_rd_en === 1'b1) b_reads++;
    if (c_rd_en === 1'b1) c_reads++;
    if (b_cpu_reset === 1'b0) b_run_cycles++;
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit use_b, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (use_b ? b_done : a_done) break;
      @(negedge clk);
    end
    check(name, 127'(use_b ? b_done : a_done), 127'd1);
  endtask

  int base_b_reads, base_b_run, base_c_reads;

  initial begin
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h11;
      got_mem[i] = exp_mem[i];
    end
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_values", pack(a_cpu_reset, a_rd_en, a_rd_addr, a_busy, a_done, a_pass, a_fc,
                               a_ffi, a_ffg, a_ffe, a_cyc), {1'b1, 126'd0});
    reset = 1'b0;

    // Full-length run with clean memory; a stray start mid-run must be ignored.
    idata = 32'd1;
    base_b_reads = b_reads;
    base_b_run   = b_run_cycles;
    pulse_start();
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("done_full_run", 1'b1, 1200);
    check("full_cycles_run", 127'(b_cyc), 127'd1000);
    check("full_cpu_run_len", 127'(b_run_cycles - base_b_run), 127'd1000);
    check("full_reads", 127'(b_reads - base_b_reads), 127'd32);
    check("full_pass", {b_pass, b_fc}, {1'b1, 16'd0});

    // Halt after 50 busy cycles, with two corrupted words.
    got_mem[5]  = 32'h0000_0007;
    exp_mem[5]  = 32'h0000_0009;
    got_mem[20] = exp_mem[20] ^ 32'h0000_0100;
    idata = 32'd1;
    pulse_start();
    repeat (50) @(negedge clk);
    idata = 32'd0;
    wait_done("done_halt_run", 1'b0, 200);
    check("halt_cycles_run", 127'(a_cyc), 127'd58);
    check("halt_fail_count", {a_pass, a_fc}, {1'b0, 16'd2});
    check("halt_first_fail", {a_ffi, a_ffg, a_ffe}, {5'd5, 32'h7, 32'h9});
    wait_done("done_nohalt_zero", 1'b1, 1200);
    check("nohalt_cycles_run", 127'(b_cyc), 127'd1000);
    got_mem[5]  = 32'hC0DE_0055;
    exp_mem[5]  = 32'hC0DE_0055;
    got_mem[20] = exp_mem[20];

    // Zero streaks of seven never trigger a halt.
    idata = 32'd1;
    pulse_start();
    for (int i = 0; i < 1200; i++) begin
      if (a_done) break;
      idata = (i % 8 == 7) ? 32'd1 : 32'd0;
      @(negedge clk);
    end
    check("streak7_done", 127'(a_done), 127'd1);
    check("streak7_cycles_run", 127'(a_cyc), 127'd1000);

    // Reset mid-dump (together with start) aborts everything; then a clean rerun.
    idata = 32'd1;
    pulse_start();
    for (int i = 0; i < 1200; i++) begin
      if (a_rd_en && a_rd_addr == 5'd10) break;
      @(negedge clk);
    end
    check("reached_dump_idx10", {a_rd_en, a_rd_addr}, {1'b1, 5'd10});
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("abort_reset_values", pack(a_cpu_reset, a_rd_en, a_rd_addr, a_busy, a_done, a_pass,
                                     a_fc, a_ffi, a_ffg, a_ffe, a_cyc), {1'b1, 126'd0});
    pulse_start();
    wait_done("done_rerun", 1'b0, 1200);
    check("rerun_result", {a_pass, a_fc, a_cyc}, {1'b1, 16'd0, 32'd1000});

    // Minimal configuration: one RUN cycle, one read, two DUMP cycles.
    base_c_reads = c_reads;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("small_run", {c_cpu_reset, c_busy}, {1'b0, 1'b1});
    @(negedge clk);
    check("small_read", {c_cpu_reset, c_rd_en, c_rd_addr}, {1'b1, 1'b1, 5'd0});
    @(negedge clk);
    check("small_compare", {c_rd_en, c_busy, c_done}, {1'b0, 1'b1, 1'b0});
    @(negedge clk);
    check("small_done", {c_done, c_pass, c_busy, c_cyc}, {1'b1, 1'b1, 1'b0, 32'd1});
    check("small_reads", 127'(c_reads - base_c_reads), 127'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
